// File: rtl/ddr_bank_timer.sv
// rtl/ddr_bank_timer.sv - per-bank DDR4 command timing tracker with ready vectors and row-hit query
module ddr_bank_timer #(
  parameter int NUM_BANKS = 16,
  parameter int ROW_W     = 17,
  parameter int tRCD      = 15,
  parameter int tRP       = 15,
  parameter int tRAS      = 33,
  parameter int tRTP      = 8,
  parameter int tWR       = 16,
  parameter int tCCD      = 4,
  parameter int CWL       = 11,
  parameter int BL        = 8,
  parameter int CNT_W     = 6,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic [BA_W-1:0]      cmd_bank,
  input  logic [ROW_W-1:0]     cmd_row,
  input  logic [BA_W-1:0]      qry_bank,
  input  logic [ROW_W-1:0]     qry_row,
  output logic [NUM_BANKS-1:0] act_rdy,
  output logic [NUM_BANKS-1:0] cas_rdy,
  output logic [NUM_BANKS-1:0] pre_rdy,
  output logic                 prea_rdy,
  output logic                 all_idle,
  output logic                 row_hit,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {
    B_IDLE        = 2'd0,
    B_ACTIVATING  = 2'd1,
    B_ACTIVE      = 2'd2,
    B_PRECHARGING = 2'd3
  } bank_state_t;

  localparam logic [2:0] CMD_DES  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  localparam int WR_REC = CWL + BL / 2 + tWR;

  // Counters are loaded with (timing - 1) at the command edge, so a value of
  // zero in cycle T+timing means the constraint has just been satisfied.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(tRCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(tRP - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(tRAS - 1);
  localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(tRTP - 1);
  localparam logic [CNT_W-1:0] WRR_LD = CNT_W'(WR_REC - 1);
  localparam logic [CNT_W-1:0] CCD_LD = CNT_W'(tCCD - 1);

  // A one-clock tRCD/tRP skips the transitional state entirely.
  localparam bank_state_t ACT_DST = (tRCD <= 1) ? B_ACTIVE : B_ACTIVATING;
  localparam bank_state_t PRE_DST = (tRP  <= 1) ? B_IDLE   : B_PRECHARGING;

  bank_state_t        st_q  [NUM_BANKS];
  bank_state_t        st_d  [NUM_BANKS];
  logic [CNT_W-1:0]   rcd_q [NUM_BANKS];
  logic [CNT_W-1:0]   rcd_d [NUM_BANKS];
  logic [CNT_W-1:0]   ras_q [NUM_BANKS];
  logic [CNT_W-1:0]   ras_d [NUM_BANKS];
  logic [CNT_W-1:0]   rp_q  [NUM_BANKS];
  logic [CNT_W-1:0]   rp_d  [NUM_BANKS];
  logic [CNT_W-1:0]   wrr_q [NUM_BANKS];
  logic [CNT_W-1:0]   wrr_d [NUM_BANKS];
  logic [CNT_W-1:0]   rtp_q [NUM_BANKS];
  logic [CNT_W-1:0]   rtp_d [NUM_BANKS];
  logic [ROW_W-1:0]   row_q [NUM_BANKS];
  logic [ROW_W-1:0]   row_d [NUM_BANKS];
  logic [CNT_W-1:0]   ccd_q;
  logic [CNT_W-1:0]   ccd_d;
  logic               cmd_err_q;

  logic [NUM_BANKS-1:0] act_raw;
  logic [NUM_BANKS-1:0] cas_raw;
  logic [NUM_BANKS-1:0] pre_raw;
  logic                 prea_raw;
  logic                 idle_raw;
  logic                 cmd_ok;
  logic                 cmd_bad;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Ready vectors from registered state only; never depend on the current command.
  always_comb begin
    act_raw  = '0;
    cas_raw  = '0;
    pre_raw  = '0;
    prea_raw = 1'b1;
    idle_raw = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_raw[b] = (st_q[b] == B_IDLE);
      cas_raw[b] = (st_q[b] == B_ACTIVE) && (ccd_q == '0);
      pre_raw[b] = (st_q[b] == B_ACTIVE) && (ras_q[b] == '0) &&
                   (wrr_q[b] == '0) && (rtp_q[b] == '0);
      if ((st_q[b] == B_ACTIVATING) || (st_q[b] == B_PRECHARGING)) begin
        prea_raw = 1'b0;
      end
      if ((st_q[b] == B_ACTIVE) && !pre_raw[b]) begin
        prea_raw = 1'b0;
      end
      if (st_q[b] != B_IDLE) begin
        idle_raw = 1'b0;
      end
    end
  end

  // Legality of the issued command against this cycle's ready vectors.
  always_comb begin
    cmd_ok  = 1'b0;
    cmd_bad = 1'b0;
    if (cmd_valid) begin
      case (cmd_type)
        CMD_DES:           cmd_ok  = 1'b0;
        CMD_ACT:           begin cmd_ok = act_raw[cmd_bank]; cmd_bad = !act_raw[cmd_bank]; end
        CMD_RD, CMD_WR:    begin cmd_ok = cas_raw[cmd_bank]; cmd_bad = !cas_raw[cmd_bank]; end
        CMD_PRE:           begin cmd_ok = pre_raw[cmd_bank]; cmd_bad = !pre_raw[cmd_bank]; end
        CMD_PREA:          begin cmd_ok = prea_raw;          cmd_bad = !prea_raw;          end
        default:           cmd_bad = 1'b1;
      endcase
    end
  end

  // Per-bank next state: timer-driven transitions first, accepted command overrides.
  always_comb begin
    ccd_d = sat_dec(ccd_q);
    if (cmd_ok && ((cmd_type == CMD_RD) || (cmd_type == CMD_WR))) begin
      ccd_d = CCD_LD;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      st_d[b]  = st_q[b];
      rcd_d[b] = sat_dec(rcd_q[b]);
      ras_d[b] = sat_dec(ras_q[b]);
      rp_d[b]  = sat_dec(rp_q[b]);
      wrr_d[b] = sat_dec(wrr_q[b]);
      rtp_d[b] = sat_dec(rtp_q[b]);
      row_d[b] = row_q[b];

      case (st_q[b])
        B_ACTIVATING:  if (rcd_q[b] <= CNT_W'(1)) st_d[b] = B_ACTIVE;
        B_PRECHARGING: if (rp_q[b]  <= CNT_W'(1)) st_d[b] = B_IDLE;
        default:       st_d[b] = st_q[b];
      endcase

      if (cmd_ok && (cmd_bank == b[BA_W-1:0])) begin
        case (cmd_type)
          CMD_ACT: begin
            st_d[b]  = ACT_DST;
            row_d[b] = cmd_row;
            rcd_d[b] = RCD_LD;
            ras_d[b] = RAS_LD;
          end
          CMD_RD:  rtp_d[b] = RTP_LD;
          CMD_WR:  wrr_d[b] = WRR_LD;
          CMD_PRE: begin
            st_d[b] = PRE_DST;
            rp_d[b] = RP_LD;
          end
          default: st_d[b] = st_d[b];
        endcase
      end

      if (cmd_ok && (cmd_type == CMD_PREA) && (st_q[b] == B_ACTIVE)) begin
        st_d[b] = PRE_DST;
        rp_d[b] = RP_LD;
      end
    end
  end

  // State, counter and open-row registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= B_IDLE;
        rcd_q[b] <= '0;
        ras_q[b] <= '0;
        rp_q[b]  <= '0;
        wrr_q[b] <= '0;
        rtp_q[b] <= '0;
        row_q[b] <= '0;
      end
      ccd_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= st_d[b];
        rcd_q[b] <= rcd_d[b];
        ras_q[b] <= ras_d[b];
        rp_q[b]  <= rp_d[b];
        wrr_q[b] <= wrr_d[b];
        rtp_q[b] <= rtp_d[b];
        row_q[b] <= row_d[b];
      end
      ccd_q     <= ccd_d;
      cmd_err_q <= cmd_bad;
    end
  end

  assign act_rdy  = reset_n ? act_raw : '0;
  assign cas_rdy  = reset_n ? cas_raw : '0;
  assign pre_rdy  = reset_n ? pre_raw : '0;
  assign prea_rdy = reset_n && prea_raw;
  assign all_idle = reset_n && idle_raw;
  assign row_hit  = reset_n && (st_q[qry_bank] == B_ACTIVE) && (row_q[qry_bank] == qry_row);
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_ddr_bank_timer.sv
// tb/tb_ddr_bank_timer.sv - table-driven bench for ddr_bank_timer
module tb_ddr_bank_timer;

  localparam logic [2:0] DES = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, PREA = 3'd5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_type = 3'd0;
  logic [3:0]  cmd_bank = 4'd0;
  logic [16:0] cmd_row = 17'd0;
  logic [3:0]  qry_bank = 4'd0;
  logic [16:0] qry_row = 17'd0;
  logic [15:0] act_rdy, cas_rdy, pre_rdy;
  logic        prea_rdy, all_idle, row_hit, cmd_err;

  int total = 0;
  int bad = 0;

  ddr_bank_timer dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .qry_bank(qry_bank), .qry_row(qry_row),
    .act_rdy(act_rdy), .cas_rdy(cas_rdy), .pre_rdy(pre_rdy), .prea_rdy(prea_rdy),
    .all_idle(all_idle), .row_hit(row_hit), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [2:0]  t;
    logic [3:0]  b;
    logic [16:0] r;
    int          n;
    logic [3:0]  qb;
    logic [16:0] qr;
    logic [15:0] act, cas, pre;
    logic        prea, idle, hit, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] t, int b, int r, int n, int qb, int qr,
                              logic [15:0] act, logic [15:0] cas, logic [15:0] pre,
                              logic prea, logic idle, logic hit, logic err);
    vec_t x;
    x.v = v; x.t = t; x.b = 4'(b); x.r = 17'(r); x.n = n; x.qb = 4'(qb); x.qr = 17'(qr);
    x.act = act; x.cas = cas; x.pre = pre; x.prea = prea; x.idle = idle; x.hit = hit; x.err = err;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_all(input int idx, input logic [15:0] act, input logic [15:0] cas,
                         input logic [15:0] pre, input logic prea, input logic idle,
                         input logic hit, input logic err);
    chk("act_rdy", idx, 32'(act_rdy), 32'(act));
    chk("cas_rdy", idx, 32'(cas_rdy), 32'(cas));
    chk("pre_rdy", idx, 32'(pre_rdy), 32'(pre));
    chk("prea_rdy", idx, 32'(prea_rdy), 32'(prea));
    chk("all_idle", idx, 32'(all_idle), 32'(idle));
    chk("row_hit", idx, 32'(row_hit), 32'(hit));
    chk("cmd_err", idx, 32'(cmd_err), 32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Each row: issue cmd in current cycle, advance n cycles, then check outputs.
    tbl.push_back(mk(0, DES,  0, 0,      0, 0, 0,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(1, ACT,  3, 'h1A5,  1, 3, 'h1A5,  16'hFFF7, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, ACT,  5, 'h00F, 13, 3, 'h1A5,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0008, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      0, 3, 'h1A6,  16'hFFD7, 16'h0008, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, RD,   3, 0,      1, 5, 'h00F,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(1, RD,   5, 0,      1, 5, 'h00F,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, DES,  0, 0,      1, 5, 'h00F,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 5, 'h00F,  16'hFFD7, 16'h0028, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(1, RD,   5, 0,      1, 5, 'h00F,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      3, 5, 'h00F,  16'hFFD7, 16'h0028, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(1, WR,   3, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      9, 3, 'h1A5,  16'hFFD7, 16'h0028, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0028, 16'h0020, 0, 0, 1, 0));
    tbl.push_back(mk(1, PRE,  3, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0028, 16'h0020, 0, 0, 1, 1));
    tbl.push_back(mk(0, DES,  0, 0,     18, 3, 'h1A5,  16'hFFD7, 16'h0028, 16'h0020, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0028, 16'h0028, 1, 0, 1, 0));
    tbl.push_back(mk(1, PRE,  3, 0,      1, 3, 'h1A5,  16'hFFD7, 16'h0020, 16'h0020, 0, 0, 0, 0));
    tbl.push_back(mk(1, PRE,  5, 0,     13, 5, 'h00F,  16'hFFD7, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 5, 'h00F,  16'hFFDF, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 5, 'h00F,  16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(1, ACT,  0, 1,      1, 0, 1,      16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, ACT,  7, 2,      1, 7, 2,      16'hFF7E, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, PREA, 0, 0,      1, 7, 2,      16'hFF7E, 16'h0000, 16'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, DES,  0, 0,     13, 7, 2,      16'hFF7E, 16'h0081, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(1, PREA, 0, 0,      1, 7, 2,      16'hFF7E, 16'h0081, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, DES,  0, 0,     16, 7, 2,      16'hFF7E, 16'h0081, 16'h0001, 0, 0, 1, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 7, 2,      16'hFF7E, 16'h0081, 16'h0081, 1, 0, 1, 0));
    tbl.push_back(mk(1, PREA, 0, 0,      1, 7, 2,      16'hFF7E, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, DES,  0, 0,     13, 7, 2,      16'hFF7E, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, DES,  0, 0,      1, 7, 2,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(1, DES,  4, 0,      1, 7, 2,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3'd6, 0, 0,      1, 7, 2,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 1));
    tbl.push_back(mk(1, RD,   9, 0,      1, 7, 2,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 1));
    tbl.push_back(mk(0, 3'd7, 0, 0,      1, 7, 2,      16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0));

    repeat (3) tick();
    reset_n = 1'b1;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].v;
      cmd_type  = tbl[i].t;
      cmd_bank  = tbl[i].b;
      cmd_row   = tbl[i].r;
      qry_bank  = tbl[i].qb;
      qry_row   = tbl[i].qr;
      if (tbl[i].n > 0) begin
        tick();
        cmd_valid = 1'b0;
        cmd_type  = DES;
        for (int k = 1; k < tbl[i].n; k++) tick();
      end
      #1;
      chk_all(i, tbl[i].act, tbl[i].cas, tbl[i].pre, tbl[i].prea, tbl[i].idle, tbl[i].hit, tbl[i].err);
    end

    // Reset asserted while bank 2 is ACTIVATING; a command during reset is ignored.
    qry_bank = 4'd2;
    qry_row  = 17'd5;
    cmd_valid = 1'b1; cmd_type = ACT; cmd_bank = 4'd2; cmd_row = 17'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    #1;
    chk("rst_act2_busy", 100, 32'(act_rdy[2]), 32'd0);
    reset_n = 1'b0;
    cmd_valid = 1'b1; cmd_type = ACT; cmd_bank = 4'd4; cmd_row = 17'd9;
    #1;
    chk_all(101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tick();
    cmd_valid = 1'b0;
    cmd_type  = DES;
    #1;
    chk_all(102, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk_all(103, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0);

    // Reserved command type 7 gives a single-cycle error pulse.
    cmd_valid = 1'b1; cmd_type = 3'd7; cmd_bank = 4'd1;
    tick();
    cmd_valid = 1'b0;
    cmd_type  = DES;
    #1;
    chk("err_type7", 104, 32'(cmd_err), 32'd1);
    chk("err_type7_act", 104, 32'(act_rdy), 32'hFFFF);
    tick();
    #1;
    chk("err_type7_drop", 105, 32'(cmd_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
